// File: rtl/game_fsm.sv
// Runner-game control FSM: IDLE/RUN/WIN/LOSE sequencing, frame-paced distance
// countdown, and pseudo-random coin/barrier lane spawning from an 8-bit LFSR.
// Every output is a register; inputs only reach outputs through a clock edge.
module game_fsm #(
  parameter logic [11:0] START_DIST   = 12'd999, // meters left at the start of a run
  parameter int unsigned DIST_DIV     = 8,       // frame ticks per meter (1..255)
  parameter int unsigned SPAWN_PERIOD = 90       // frame ticks between spawns (1..255)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_tick,
  input  logic        i_start,
  input  logic        i_coin_hit,
  input  logic        i_barrier_hit,
  input  logic        i_zero_lives,
  output logic [7:0]  o_state,
  output logic [11:0] o_remaining_distance,
  output logic [1:0]  o_active_coin,
  output logic [1:0]  o_active_barrier,
  output logic        o_win,
  output logic        o_lose
);

  // State codes are visible on o_state, so the encoding is fixed, not left to synthesis.
  typedef enum logic [7:0] {
    ST_IDLE = 8'h00,
    ST_RUN  = 8'h01,
    ST_WIN  = 8'h02,
    ST_LOSE = 8'h03
  } state_e;

  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  localparam logic [7:0] DIV_LAST   = 8'(DIST_DIV - 1);
  localparam logic [7:0] SPAWN_LAST = 8'(SPAWN_PERIOD - 1);
  localparam logic [1:0] LANE_NONE  = 2'b00;

  state_e      state_q, state_d;
  logic [11:0] dist_q, dist_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  spawn_cnt_q, spawn_cnt_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [1:0]  coin_q, coin_d;
  logic [1:0]  barrier_q, barrier_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;

  // Qualified tick events shared by the counter and lane logic.
  logic        run_tick;
  logic        dist_step;
  logic        spawn_now;
  logic [1:0]  spawn_coin;
  logic [1:0]  spawn_barrier;

  // Tick qualifiers: counters only move while running.
  always_comb begin
    run_tick  = (state_q == ST_RUN) && i_frame_tick;
    dist_step = run_tick && (frame_cnt_q == DIV_LAST);
    spawn_now = run_tick && (spawn_cnt_q == SPAWN_LAST);
  end

  // Next-state logic; losing outranks winning when both are due in one cycle.
  always_comb begin
    // NOTE: every signal driven in a combinational block gets a default first,
    // so no branch can leave it unassigned and infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_zero_lives)         state_d = ST_LOSE;
        else if (dist_q == 12'd0) state_d = ST_WIN;
      end
      ST_WIN, ST_LOSE: begin
        if (i_start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Free-running LFSR (x^8+x^6+x^5+x^4+1), stepped by every frame tick in any state.
  always_comb begin
    lfsr_d = lfsr_q;
    if (i_frame_tick) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    // The polynomial is maximal-length, so all-zeros is unreachable from the
    // seed; reseeding here only guards against an upset flop.
    if (lfsr_d == 8'h00) lfsr_d = LFSR_SEED;
  end

  // Frame/spawn counters and the distance countdown.
  always_comb begin
    dist_d      = dist_q;
    frame_cnt_d = frame_cnt_q;
    spawn_cnt_d = spawn_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // Parked at the start line so a run always begins from a clean phase.
        dist_d      = START_DIST;
        frame_cnt_d = 8'd0;
        spawn_cnt_d = 8'd0;
      end
      ST_RUN: begin
        if (run_tick) begin
          frame_cnt_d = dist_step ? 8'd0 : frame_cnt_q + 8'd1;
          spawn_cnt_d = spawn_now ? 8'd0 : spawn_cnt_q + 8'd1;
        end
        if (dist_step && (dist_q != 12'd0)) begin
          dist_d = dist_q - 12'd1;
        end
      end
      ST_WIN, ST_LOSE: begin
        // Counters and distance freeze on the end screen until restart.
        if (i_start) dist_d = START_DIST;
      end
      default: begin
        dist_d      = START_DIST;
        frame_cnt_d = 8'd0;
        spawn_cnt_d = 8'd0;
      end
    endcase
  end

  // Candidate lanes from the pre-advance LFSR; a barrier never shares the coin's lane.
  always_comb begin
    spawn_coin    = lfsr_q[1:0];
    spawn_barrier = lfsr_q[3:2];
    if ((lfsr_q[3:2] == lfsr_q[1:0]) && (lfsr_q[1:0] != LANE_NONE)) begin
      spawn_barrier = LANE_NONE;
    end
  end

  // Active lanes: a spawn beats a same-cycle hit; lanes are empty outside RUN.
  always_comb begin
    coin_d    = coin_q;
    barrier_d = barrier_q;
    if (state_q == ST_RUN) begin
      if (spawn_now) begin
        coin_d    = spawn_coin;
        barrier_d = spawn_barrier;
      end else begin
        if (i_coin_hit)    coin_d    = LANE_NONE;
        if (i_barrier_hit) barrier_d = LANE_NONE;
      end
    end
    if (state_d != ST_RUN) begin
      coin_d    = LANE_NONE;
      barrier_d = LANE_NONE;
    end
  end

  // Win/lose flags follow the next state so they are registered alongside it.
  always_comb begin
    win_d  = (state_d == ST_WIN);
    lose_d = (state_d == ST_LOSE);
  end

  // State and datapath registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs and they all update together.
    if (i_rst) begin
      state_q     <= ST_IDLE;
      dist_q      <= START_DIST;
      frame_cnt_q <= 8'd0;
      spawn_cnt_q <= 8'd0;
      lfsr_q      <= LFSR_SEED;
      coin_q      <= LANE_NONE;
      barrier_q   <= LANE_NONE;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dist_q      <= dist_d;
      frame_cnt_q <= frame_cnt_d;
      spawn_cnt_q <= spawn_cnt_d;
      lfsr_q      <= lfsr_d;
      coin_q      <= coin_d;
      barrier_q   <= barrier_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
    end
  end

  assign o_state              = state_q;
  assign o_remaining_distance = dist_q;
  assign o_active_coin        = coin_q;
  assign o_active_barrier     = barrier_q;
  assign o_win                = win_q;
  assign o_lose               = lose_q;

endmodule

// File: tb/tb_game_fsm.sv
// Self-checking bench for game_fsm (START_DIST=3, DIST_DIV=2, SPAWN_PERIOD=4):
// directed scenarios followed by random traffic, all compared every cycle
// against a tick-counting reference model.
module tb_game_fsm;

  localparam int START = 3;
  localparam int DIV   = 2;
  localparam int SP    = 4;

  localparam logic [7:0] S_IDLE = 8'h00;
  localparam logic [7:0] S_RUN  = 8'h01;
  localparam logic [7:0] S_WIN  = 8'h02;
  localparam logic [7:0] S_LOSE = 8'h03;

  logic        clk = 1'b0;
  logic        rst, start, tick, coin_hit, barrier_hit, zero_lives;
  logic [7:0]  o_state;
  logic [11:0] o_remaining_distance;
  logic [1:0]  o_active_coin, o_active_barrier;
  logic        o_win, o_lose;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: distance is derived from ticks counted since the run began.
  logic [7:0] m_state;
  int         m_dist;
  int         m_ticks;
  logic [7:0] m_lfsr;
  logic [1:0] m_coin, m_bar;

  game_fsm #(
    .START_DIST  (12'd3),
    .DIST_DIV    (2),
    .SPAWN_PERIOD(4)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_frame_tick        (tick),
    .i_start             (start),
    .i_coin_hit          (coin_hit),
    .i_barrier_hit       (barrier_hit),
    .i_zero_lives        (zero_lives),
    .o_state             (o_state),
    .o_remaining_distance(o_remaining_distance),
    .o_active_coin       (o_active_coin),
    .o_active_barrier    (o_active_barrier),
    .o_win               (o_win),
    .o_lose              (o_lose)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  task automatic model_update();
    logic [7:0] pre;
    logic [7:0] nxt;
    bit         spawn;
    if (rst) begin
      m_state = S_IDLE; m_dist = START; m_ticks = 0;
      m_lfsr = 8'hA5; m_coin = 2'b00; m_bar = 2'b00;
      return;
    end
    pre   = m_lfsr;
    nxt   = m_state;
    spawn = 1'b0;
    if (tick) m_lfsr = lfsr_adv(pre);
    case (m_state)
      S_IDLE: begin
        m_dist = START; m_ticks = 0; m_coin = 2'b00; m_bar = 2'b00;
        if (start) nxt = S_RUN;
      end
      S_RUN: begin
        if (zero_lives)       nxt = S_LOSE;
        else if (m_dist == 0) nxt = S_WIN;
        if (tick) begin
          m_ticks++;
          m_dist = (m_ticks / DIV >= START) ? 0 : START - m_ticks / DIV;
          spawn  = (m_ticks % SP) == 0;
        end
        if (spawn) begin
          m_coin = pre[1:0];
          m_bar  = (pre[3:2] == pre[1:0] && pre[1:0] != 2'b00) ? 2'b00 : pre[3:2];
        end else begin
          if (coin_hit)    m_coin = 2'b00;
          if (barrier_hit) m_bar  = 2'b00;
        end
        if (nxt != S_RUN) begin m_coin = 2'b00; m_bar = 2'b00; end
      end
      default: begin
        m_coin = 2'b00; m_bar = 2'b00;
        if (start) begin nxt = S_IDLE; m_dist = START; end
      end
    endcase
    m_state = nxt;
  endtask

  task automatic check_all(input string tag);
    check({tag, ":state"},   32'(o_state),              32'(m_state));
    check({tag, ":dist"},    32'(o_remaining_distance), 32'(m_dist));
    check({tag, ":coin"},    32'(o_active_coin),        32'(m_coin));
    check({tag, ":barrier"}, 32'(o_active_barrier),     32'(m_bar));
    check({tag, ":win"},     32'(o_win),                32'(m_state == S_WIN));
    check({tag, ":lose"},    32'(o_lose),               32'(m_state == S_LOSE));
  endtask

  // One clock with the currently driven inputs; outputs sampled 1 time unit after the edge.
  task automatic step(input string tag);
    model_update();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic r, input logic s, input logic t,
                       input logic c, input logic b, input logic z);
    rst = r; start = s; tick = t; coin_hit = c; barrier_hit = b; zero_lives = z;
  endtask

  initial begin
    int exp_dist[7];
    exp_dist = '{3, 3, 2, 2, 1, 1, 0};

    // Reset, then start: IDLE -> RUN one edge later at full distance.
    drive(1, 0, 0, 0, 0, 0); step("rst"); step("rst");
    check("reset_state", 32'(o_state), 32'(S_IDLE));
    check("reset_dist",  32'(o_remaining_distance), 3);
    drive(0, 0, 0, 0, 0, 0); step("idle");
    drive(0, 1, 0, 0, 0, 0); step("start");
    check("start_state", 32'(o_state), 32'(S_RUN));
    check("start_dist",  32'(o_remaining_distance), 3);

    // Six ticks count the distance down 3,3,2,2,1,1,0; WIN follows one edge after 0.
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 1, 0, 0, 0); step("countdown");
      check($sformatf("dist_after_tick%0d", k), 32'(o_remaining_distance), 32'(exp_dist[k]));
      if (k == 6) check("still_run_at_zero", 32'(o_state), 32'(S_RUN));
      drive(0, 0, 0, 0, 0, 0); step("gap");
    end
    check("win_state", 32'(o_state), 32'(S_WIN));
    check("win_flag",  32'(o_win), 1);

    // Start from WIN returns to IDLE with the distance reloaded.
    drive(0, 1, 0, 0, 0, 0); step("win_restart");
    check("win_to_idle",      32'(o_state), 32'(S_IDLE));
    check("win_to_idle_dist", 32'(o_remaining_distance), 3);

    // 252 idle ticks + 3 run ticks = 255 steps of a period-255 LFSR, so the
    // 4th run tick spawns from 8'hA5: coin 01, barrier 01 dropped to 00.
    drive(1, 0, 0, 0, 0, 0); step("rst");
    drive(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 252; k++) step("idle_tick");
    drive(0, 1, 0, 0, 0, 0); step("start");
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0, 0, 0); step("pre_spawn");
      drive(0, 0, 0, 0, 0, 0); step("gap");
    end
    drive(0, 0, 1, 0, 0, 0); step("spawn_a5");
    check("spawn_a5_coin",    32'(o_active_coin), 32'(2'b01));
    check("spawn_a5_barrier", 32'(o_active_barrier), 32'(2'b00));
    drive(0, 0, 0, 1, 0, 0); step("coin_hit");
    check("coin_hit_clears", 32'(o_active_coin), 32'(2'b00));

    // One idle tick + 3 run ticks: spawn from 8'h54 (coin 00, barrier 01) with a
    // coincident barrier hit that must not clear the new barrier.
    drive(1, 0, 0, 0, 0, 0); step("rst");
    drive(0, 0, 1, 0, 0, 0); step("idle_tick");
    drive(0, 1, 0, 0, 0, 0); step("start");
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0, 0, 0); step("pre_spawn");
    end
    drive(0, 0, 1, 0, 1, 0); step("spawn_vs_hit");
    check("spawn_beats_hit", 32'(o_active_barrier), 32'(2'b01));
    drive(0, 0, 0, 0, 1, 0); step("barrier_hit");
    check("barrier_hit_clears", 32'(o_active_barrier), 32'(2'b00));

    // Zero lives on the same tick as the last meter: LOSE wins over WIN.
    drive(1, 0, 0, 0, 0, 0); step("rst");
    drive(0, 1, 0, 0, 0, 0); step("start");
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 0, 0, 0); step("run_tick");
    end
    drive(0, 0, 1, 0, 0, 1); step("lose_vs_zero");
    check("lose_state",   32'(o_state), 32'(S_LOSE));
    check("lose_flag",    32'(o_lose), 1);
    check("lose_coin",    32'(o_active_coin), 0);
    check("lose_barrier", 32'(o_active_barrier), 0);
    drive(0, 0, 1, 1, 1, 0); step("lose_hold");
    check("lose_holds", 32'(o_state), 32'(S_LOSE));

    // Reset mid-run at distance 2 overrides every other input and reseeds the LFSR.
    drive(1, 0, 0, 0, 0, 0); step("rst");
    drive(0, 1, 0, 0, 0, 0); step("start");
    drive(0, 0, 1, 0, 0, 0); step("run_tick"); step("run_tick");
    check("midrun_dist", 32'(o_remaining_distance), 2);
    drive(1, 1, 1, 1, 1, 1); step("midrun_rst");
    check("midrun_rst_state", 32'(o_state), 32'(S_IDLE));
    check("midrun_rst_dist",  32'(o_remaining_distance), 3);
    drive(0, 1, 0, 0, 0, 0); step("start");
    drive(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step("reseed_tick");
    // Seed A5 stepped 3 times is 8'h2A: coin 10, barrier 10 dropped to 00.
    check("reseed_coin",    32'(o_active_coin), 32'(2'b10));
    check("reseed_barrier", 32'(o_active_barrier), 32'(2'b00));

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) == 0,   $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,   $urandom_range(0, 29) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
